// File: rtl/xadac_pkg.sv
// Shared xadac interface types and the vdotp encoding constants.
package xadac_pkg;

   localparam int unsigned IdWidth      = 4;
   localparam int unsigned InstrWidth   = 32;
   localparam int unsigned RegAddrWidth = 5;
   localparam int unsigned RegDataWidth = 32;
   localparam int unsigned VecAddrWidth = 5;
   localparam int unsigned VecDataWidth = 128;
   localparam int unsigned VecElemWidth = 8;
   localparam int unsigned NoRs         = 2;
   localparam int unsigned NoVs         = 3;
   localparam int unsigned VecNoElem    = VecDataWidth / VecElemWidth;

   localparam logic [6:0] VDOTP_OPCODE = 7'b0001011;
   localparam logic [2:0] VDOTP_S      = 3'b000;
   localparam logic [2:0] VDOTP_U      = 3'b001;

   typedef struct packed {
      logic [IdWidth-1:0]    id;
      logic [InstrWidth-1:0] instr;
   } DecReqT;

   typedef struct packed {
      logic [IdWidth-1:0] id;
      logic               accept;
      logic               rd_clobber;
      logic               vd_clobber;
      logic [NoRs-1:0]    rs_read;
      logic [NoVs-1:0]    vs_read;
   } DecRspT;

   typedef struct packed {
      logic [IdWidth-1:0]                    id;
      logic [InstrWidth-1:0]                 instr;
      logic [NoRs-1:0][RegDataWidth-1:0]     rs_data;
      logic [NoVs-1:0][VecDataWidth-1:0]     vs_data;
   } ExeReqT;

   typedef struct packed {
      logic [IdWidth-1:0]      id;
      logic [RegAddrWidth-1:0] rd_addr;
      logic [RegDataWidth-1:0] rd_data;
      logic                    rd_write;
      logic [VecAddrWidth-1:0] vd_addr;
      logic [VecDataWidth-1:0] vd_data;
      logic                    vd_write;
   } ExeRspT;

   // True for the signed and unsigned vdotp encodings; operand fields are ignored.
   function automatic logic isVdotp(input logic [InstrWidth-1:0] instr);
      return (instr[6:0] == VDOTP_OPCODE) &&
             ((instr[14:12] == VDOTP_S) || (instr[14:12] == VDOTP_U));
   endfunction

endpackage

// File: rtl/xadac_vdotp_mac.sv
// Combinational lane MAC: sum of masked, sign- or zero-extended 8x8 products.
module xadac_vdotp_mac
   import xadac_pkg::*;
#(
   parameter int unsigned Lanes = 4
) (
   input  logic [Lanes*VecElemWidth-1:0] vecA,
   input  logic [Lanes*VecElemWidth-1:0] vecB,
   input  logic [Lanes-1:0]              laneValid,
   input  logic                          signedOp,
   output logic [RegDataWidth-1:0]       partialSum
);

   function automatic logic [31:0] mulExt(input logic [7:0] a, input logic [7:0] b,
                                          input logic isSigned);
      logic signed [15:0] sProd;
      logic [15:0]        uProd;
      sProd = $signed({{8{a[7]}}, a}) * $signed({{8{b[7]}}, b});
      uProd = {8'b0, a} * {8'b0, b};
      return isSigned ? {{16{sProd[15]}}, sProd} : {16'b0, uProd};
   endfunction

   // Add every valid lane's extended product; masked lanes contribute nothing.
   always_comb begin
      partialSum = '0;
      for (int unsigned l = 0; l < Lanes; l++) begin
         if (laneValid[l]) begin
            partialSum = partialSum + mulExt(vecA[l*VecElemWidth +: VecElemWidth],
                                             vecB[l*VecElemWidth +: VecElemWidth],
                                             signedOp);
         end
      end
   end

endmodule

// File: rtl/xadac_vdotp.sv
// xadac responder: registered decode path plus an iterative dot-product-accumulate unit.
module xadac_vdotp
   import xadac_pkg::*;
#(
   parameter int unsigned Lanes = 4
) (
   input  logic   clk,
   input  logic   rst,
   input  logic   dec_req_valid,
   output logic   dec_req_ready,
   input  DecReqT dec_req,
   output logic   dec_rsp_valid,
   input  logic   dec_rsp_ready,
   output DecRspT dec_rsp,
   input  logic   exe_req_valid,
   output logic   exe_req_ready,
   input  ExeReqT exe_req,
   output logic   exe_rsp_valid,
   input  logic   exe_rsp_ready,
   output ExeRspT exe_rsp
);

   typedef enum logic [1:0] {IDLE, CALC, RESP} stateT;

   stateT                   state, stateNext;
   logic                    decValidQ;
   DecRspT                  decRspQ, decRspNext;
   logic [IdWidth-1:0]      idQ;
   logic [RegAddrWidth-1:0] rdAddrQ;
   logic                    legalQ, signedQ;
   logic [RegDataWidth-1:0] accQ;
   logic [4:0]              lenQ, elemBase;
   logic [VecDataWidth-1:0] vs1Q, vs2Q;
   logic [Lanes-1:0]        laneValid;
   logic [RegDataWidth-1:0] partialSum;
   logic                    unusedVs2;

   assign unusedVs2 = ^exe_req.vs_data[2];

   // ---------------- decode path ----------------
   assign dec_req_ready = !decValidQ || dec_rsp_ready;
   assign dec_rsp_valid = decValidQ;
   assign dec_rsp       = decRspQ;

   // Build the decode answer for the request currently presented.
   always_comb begin
      decRspNext    = '0;
      decRspNext.id = dec_req.id;
      if (isVdotp(dec_req.instr)) begin
         decRspNext.accept     = 1'b1;
         decRspNext.rd_clobber = 1'b1;
         decRspNext.rs_read    = 2'b11;
         decRspNext.vs_read    = 3'b011;
      end
   end

   // Single output register; holds the response until it is taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         decValidQ <= 1'b0;
         decRspQ   <= '0;
      end else if (dec_req_valid && dec_req_ready) begin
         decValidQ <= 1'b1;
         decRspQ   <= decRspNext;
      end else if (dec_rsp_ready) begin
         decValidQ <= 1'b0;
      end
   end

   // ---------------- execute path ----------------
   // Vectors shift down by one lane group per CALC cycle, so the MAC always sees the low lanes.
   always_comb begin
      laneValid = '0;
      for (int unsigned l = 0; l < Lanes; l++) begin
         laneValid[l] = (elemBase + 5'(l)) < lenQ;
      end
   end

   xadac_vdotp_mac #(.Lanes(Lanes)) mac (
      .vecA      (vs1Q[Lanes*VecElemWidth-1:0]),
      .vecB      (vs2Q[Lanes*VecElemWidth-1:0]),
      .laneValid (laneValid),
      .signedOp  (signedQ),
      .partialSum(partialSum)
   );

   // FSM state register.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= stateNext;
   end

   // Next state and handshake/response outputs.
   always_comb begin
      stateNext     = state;
      exe_req_ready = 1'b0;
      exe_rsp_valid = 1'b0;
      exe_rsp       = '0;
      case (state)
         IDLE: begin
            exe_req_ready = 1'b1;
            if (exe_req_valid) stateNext = CALC;
         end
         CALC: begin
            if (elemBase == 5'(VecNoElem - Lanes)) stateNext = RESP;
         end
         RESP: begin
            exe_rsp_valid    = 1'b1;
            exe_rsp.id       = idQ;
            exe_rsp.rd_addr  = rdAddrQ;
            exe_rsp.rd_data  = legalQ ? accQ : '0;
            exe_rsp.rd_write = legalQ;
            if (exe_rsp_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Operand capture on accept, then one lane group accumulated per CALC cycle.
   always_ff @(posedge clk) begin
      if (rst) begin
         idQ      <= '0;
         rdAddrQ  <= '0;
         legalQ   <= 1'b0;
         signedQ  <= 1'b0;
         accQ     <= '0;
         lenQ     <= '0;
         elemBase <= '0;
         vs1Q     <= '0;
         vs2Q     <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (exe_req_valid) begin
                  idQ      <= exe_req.id;
                  rdAddrQ  <= exe_req.instr[11:7];
                  legalQ   <= isVdotp(exe_req.instr);
                  signedQ  <= (exe_req.instr[14:12] == VDOTP_S);
                  accQ     <= exe_req.rs_data[0];
                  lenQ     <= (exe_req.rs_data[1] > 32'(VecNoElem)) ? 5'(VecNoElem)
                                                                    : exe_req.rs_data[1][4:0];
                  elemBase <= '0;
                  vs1Q     <= exe_req.vs_data[0];
                  vs2Q     <= exe_req.vs_data[1];
               end
            end
            CALC: begin
               accQ     <= accQ + partialSum;
               vs1Q     <= vs1Q >> (Lanes * VecElemWidth);
               vs2Q     <= vs2Q >> (Lanes * VecElemWidth);
               elemBase <= elemBase + 5'(Lanes);
            end
            default: ;
         endcase
      end
   end

endmodule
